// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss.cc stopwatch controller.
package stopwatch_pkg;

    // Controller states; the encoding is visible on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_t;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // All six digits at zero: 00:00.00.
    localparam logic [23:0] TIME_ZERO = 24'h0;

    // Largest value a digit can hold before rolling over.
    localparam bcd_t DIGIT_MAX_9 = 4'd9;
    localparam bcd_t DIGIT_MAX_5 = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// Single BCD digit with synchronous clear, increment and rollover carry.
// Chained through carry to form a multi-digit counter.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX_9
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    // Carry out fires on the increment that rolls this digit back to zero.
    assign carry = inc && (q == MAX);

    // Digit register: clear wins over increment, rolls over at MAX.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop, lap and clear pulses drive a four-state
// FSM, a 1/100 s prescaler and a six-digit BCD time counter. The display
// word is registered; in LAP it shows the frozen lap value while the time
// keeps counting underneath.
//
// Handshake: start_pulse, lap_pulse and clear_pulse are single-cycle strobes
// with no ready/acknowledge; every high cycle is sampled as a press, and when
// several are high together only the highest priority one (clear > start >
// lap) is considered, the others are dropped.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int DIV_W    = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_pulse,
    input  logic        lap_pulse,
    input  logic        clear_pulse,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        frozen,
    output logic        wrap,
    output logic [1:0]  state_dbg
);

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    sw_state_t        state;
    sw_state_t        next_state;
    logic             lap_capture;
    logic             time_clr;
    logic             counting;
    logic             tick;
    logic [DIV_W-1:0] presc;
    logic [23:0]      lap_reg;
    logic [23:0]      time_bcd;

    bcd_t cs_o, cs_t, sec_o, sec_t, min_o, min_t;
    logic c_cs_o, c_cs_t, c_sec_o, c_sec_t, c_min_o, c_min_t;

    assign counting  = (state == ST_RUN) || (state == ST_LAP);
    assign tick      = counting && (presc == TICK_LAST);
    assign running   = counting;
    assign frozen    = (state == ST_LAP);
    assign state_dbg = state;
    assign time_bcd  = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, lap capture and time clear from the prioritised pulses.
    always_comb begin
        next_state  = state;
        lap_capture = 1'b0;
        time_clr    = 1'b0;
        if (clear_pulse) begin
            if (state == ST_PAUSE) begin
                next_state = ST_IDLE;
                time_clr   = 1'b1;
            end
        end else if (start_pulse) begin
            case (state)
                ST_IDLE:  next_state = ST_RUN;
                ST_RUN:   next_state = ST_PAUSE;
                ST_LAP:   next_state = ST_PAUSE;
                ST_PAUSE: next_state = ST_RUN;
                default:  next_state = ST_IDLE;
            endcase
        end else if (lap_pulse) begin
            case (state)
                ST_RUN: begin
                    next_state  = ST_LAP;
                    lap_capture = 1'b1;
                end
                ST_LAP:  next_state = ST_RUN;
                default: next_state = state;
            endcase
        end
    end

    // Prescaler: counts only while running, holds its phase across a pause.
    always_ff @(posedge clock) begin
        if (reset || time_clr) begin
            presc <= '0;
        end else if (counting) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs_o (
        .clock(clock), .reset(reset), .clr(time_clr),
        .inc(tick), .q(cs_o), .carry(c_cs_o)
    );
    bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs_t (
        .clock(clock), .reset(reset), .clr(time_clr),
        .inc(c_cs_o), .q(cs_t), .carry(c_cs_t)
    );
    bcd_digit #(.MAX(DIGIT_MAX_9)) u_sec_o (
        .clock(clock), .reset(reset), .clr(time_clr),
        .inc(c_cs_t), .q(sec_o), .carry(c_sec_o)
    );
    bcd_digit #(.MAX(DIGIT_MAX_5)) u_sec_t (
        .clock(clock), .reset(reset), .clr(time_clr),
        .inc(c_sec_o), .q(sec_t), .carry(c_sec_t)
    );
    bcd_digit #(.MAX(DIGIT_MAX_9)) u_min_o (
        .clock(clock), .reset(reset), .clr(time_clr),
        .inc(c_sec_t), .q(min_o), .carry(c_min_o)
    );
    bcd_digit #(.MAX(DIGIT_MAX_5)) u_min_t (
        .clock(clock), .reset(reset), .clr(time_clr),
        .inc(c_min_o), .q(min_t), .carry(c_min_t)
    );

    // Wrap strobe: the top digit's carry only fires on 59:59.99 -> 00:00.00.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= c_min_t;
        end
    end

    // Lap register: snapshot of the pre-increment time when lap is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            lap_reg <= TIME_ZERO;
        end else if (lap_capture) begin
            lap_reg <= time_bcd;
        end
    end

    // Display: live time, except while staying in LAP where the snapshot is
    // held. The entry edge loads live time, which equals the snapshot value.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_bcd <= TIME_ZERO;
        end else if ((state == ST_LAP) && (next_state == ST_LAP)) begin
            disp_bcd <= lap_reg;
        end else begin
            disp_bcd <= time_bcd;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a TICK_DIV=4 instance for the control
// paths and a TICK_DIV=2 instance for the full-hour wrap.
module tb_stopwatch_ctrl;

    logic        clock;
    logic        reset;
    logic        start_pulse, lap_pulse, clear_pulse;
    logic [23:0] disp_bcd;
    logic        running, frozen, wrap;
    logic [1:0]  state_dbg;

    logic        w_start, w_lap, w_clear;
    logic [23:0] w_disp;
    logic        w_running, w_frozen, w_wrap;
    logic [1:0]  w_state;

    int n_vec;
    int n_miss;
    int n_wrap;

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    stopwatch_ctrl #(.TICK_DIV(4), .DIV_W(4)) dut (
        .clock(clock), .reset(reset),
        .start_pulse(start_pulse), .lap_pulse(lap_pulse), .clear_pulse(clear_pulse),
        .disp_bcd(disp_bcd), .running(running), .frozen(frozen), .wrap(wrap),
        .state_dbg(state_dbg)
    );

    stopwatch_ctrl #(.TICK_DIV(2), .DIV_W(2)) dut_w (
        .clock(clock), .reset(reset),
        .start_pulse(w_start), .lap_pulse(w_lap), .clear_pulse(w_clear),
        .disp_bcd(w_disp), .running(w_running), .frozen(w_frozen), .wrap(w_wrap),
        .state_dbg(w_state)
    );

    // scoreboard check
    task automatic check_vec(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs are read there too
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        start_pulse = s;
        lap_pulse   = l;
        clear_pulse = c;
        @(negedge clock);
        start_pulse = 1'b0;
        lap_pulse   = 1'b0;
        clear_pulse = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        n_wrap = 0;
        reset = 1'b1;
        start_pulse = 1'b0; lap_pulse = 1'b0; clear_pulse = 1'b0;
        w_start = 1'b0; w_lap = 1'b0; w_clear = 1'b0;

        // 1: reset state, then idle with no presses
        step(3);
        check_vec("rst_disp", disp_bcd, 24'h000000);
        check_vec("rst_running", 24'(running), 24'd0);
        check_vec("rst_frozen", 24'(frozen), 24'd0);
        check_vec("rst_wrap", 24'(wrap), 24'd0);
        check_vec("rst_state", 24'(state_dbg), 24'd0);
        reset = 1'b0;
        step(1000);
        check_vec("idle_disp", disp_bcd, 24'h000000);
        check_vec("idle_running", 24'(running), 24'd0);

        // 2: start; first tick 4 cycles after RUN, display one cycle later
        press(1'b1, 1'b0, 1'b0);                       // edge 0: RUN
        check_vec("run_running", 24'(running), 24'd1);
        check_vec("run_state", 24'(state_dbg), 24'd1);
        step(4);
        check_vec("first_tick_pre", disp_bcd, 24'h000000);
        step(1);
        check_vec("first_tick", disp_bcd, 24'h000001);
        step(396);                                      // edge 401
        check_vec("one_second", disp_bcd, 24'h000100);
        check_vec("one_second_run", 24'(running), 24'd1);

        // 3: lap at 00:02.37, hold 200 cycles, release to live 00:02.87
        step(548);                                      // edge 949
        press(1'b0, 1'b1, 1'b0);                        // edge 950
        check_vec("lap_frozen", 24'(frozen), 24'd1);
        check_vec("lap_disp", disp_bcd, 24'h000237);
        step(200);
        check_vec("lap_hold", disp_bcd, 24'h000237);
        check_vec("lap_hold_frozen", 24'(frozen), 24'd1);
        press(1'b0, 1'b1, 1'b0);                        // edge 1151
        check_vec("lap_rel_frozen", 24'(frozen), 24'd0);
        check_vec("lap_rel_running", 24'(running), 24'd1);
        check_vec("lap_rel_disp", disp_bcd, 24'h000287);

        // 4: pause at 00:05.00, resume keeps prescaler phase, clear+start
        step(850);                                      // edge 2001
        press(1'b1, 1'b0, 1'b0);                        // edge 2002: PAUSE
        check_vec("pause_running", 24'(running), 24'd0);
        check_vec("pause_state", 24'(state_dbg), 24'd3);
        check_vec("pause_disp", disp_bcd, 24'h000500);
        step(100);
        check_vec("pause_hold", disp_bcd, 24'h000500);
        press(1'b1, 1'b0, 1'b0);                        // resume, prescaler at 2
        check_vec("resume_running", 24'(running), 24'd1);
        step(2);
        check_vec("resume_pre", disp_bcd, 24'h000500);
        step(1);
        check_vec("resume_tick", disp_bcd, 24'h000501);
        press(1'b1, 1'b0, 1'b0);                        // PAUSE again
        press(1'b1, 1'b0, 1'b1);                        // clear beats start
        check_vec("clear_running", 24'(running), 24'd0);
        check_vec("clear_state", 24'(state_dbg), 24'd0);
        step(1);
        check_vec("clear_disp", disp_bcd, 24'h000000);

        // tick coinciding with start: increment lands, then pause
        press(1'b1, 1'b0, 1'b0);                        // edge 0: RUN
        step(3);
        press(1'b1, 1'b0, 1'b0);                        // edge 4: tick + stop
        check_vec("tick_stop_running", 24'(running), 24'd0);
        step(20);
        check_vec("tick_stop_disp", disp_bcd, 24'h000001);

        // 6: lap on a tick edge at 00:03.45, then reset while in LAP
        press(1'b0, 1'b0, 1'b1);                        // PAUSE -> IDLE
        step(1);
        press(1'b1, 1'b0, 1'b0);                        // edge 0: RUN
        step(1383);
        press(1'b0, 1'b1, 1'b0);                        // edge 1384: tick + lap
        check_vec("lap_tick_disp", disp_bcd, 24'h000345);
        step(10);
        check_vec("lap_tick_hold", disp_bcd, 24'h000345);
        reset = 1'b1;
        step(1);
        check_vec("midrst_disp", disp_bcd, 24'h000000);
        check_vec("midrst_running", 24'(running), 24'd0);
        check_vec("midrst_frozen", 24'(frozen), 24'd0);
        check_vec("midrst_wrap", 24'(wrap), 24'd0);
        reset = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        step(4);
        check_vec("after_rst_pre", disp_bcd, 24'h000000);
        step(1);
        check_vec("after_rst_tick", disp_bcd, 24'h000001);

        // 5: full hour on the TICK_DIV=2 instance
        w_start = 1'b1;
        @(negedge clock);                               // edge 0: RUN
        w_start = 1'b0;
        for (int i = 1; i <= 720003; i++) begin
            @(negedge clock);
            if (w_wrap) n_wrap++;
            if (i == 720000) begin
                check_vec("wrap_pulse", 24'(w_wrap), 24'd1);
                check_vec("wrap_last", w_disp, 24'h595999);
            end
            if (i == 720001) begin
                check_vec("wrap_zero", w_disp, 24'h000000);
                check_vec("wrap_width", 24'(w_wrap), 24'd0);
            end
            if (i == 720003) begin
                check_vec("wrap_resume", w_disp, 24'h000001);
            end
        end
        check_vec("wrap_count", 24'(n_wrap), 24'd1);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Mm:ss.cc stopwatch controller that consumes the single-cycle button pulses produced by the debounced edge-detect stage.
- Three pulse inputs (start/stop, lap, clear) drive a 4-state FSM, a clock prescaler and a 6-digit BCD time counter.
- Presents a registered 24-bit BCD display word to the downstream 7-segment/LCD driver.

Parameters:
TICK_DIV, 500000, clock cycles per 1/100 s tick (50 MHz board clock); legal range >= 2
DIV_W, 20, prescaler width; must satisfy 2**DIV_W >= TICK_DIV

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
start_pulse  input  1  one-cycle pulse, start/stop toggle
lap_pulse  input  1  one-cycle pulse, lap freeze/release
clear_pulse  input  1  one-cycle pulse, zero the time
disp_bcd  output  24  {min_t,min_o,sec_t,sec_o,cs_t,cs_o}, 4 bits per BCD digit
running  output  1  high in RUN or LAP
frozen  output  1  high in LAP (display held)
wrap  output  1  one-cycle pulse when time rolls 59:59.99 -> 00:00.00

Behaviour:
- Reset:
  - Reset is synchronous, active-high; clock is clock.
  - Reset forces state IDLE, prescaler 0, time 00:00.00, lap register 0, disp_bcd 0, running 0, frozen 0, wrap 0.
  - Reset mid-run has the same effect; no partial state survives.
- FSM states IDLE, RUN, LAP, PAUSE. Pulses are evaluated each cycle with priority clear > start > lap; lower-priority pulses in the same cycle are discarded.
  - IDLE: start -> RUN; lap, clear ignored.
  - RUN: start -> PAUSE; lap -> LAP (capture time into lap register); clear ignored.
  - LAP: start -> PAUSE (display unfreezes, shows live time); lap -> RUN (release); clear ignored.
  - PAUSE: start -> RUN (resume, prescaler keeps its value); clear -> IDLE (time and prescaler zeroed); lap ignored.
- Latency: a pulse at edge n changes the state, running and frozen at edge n+1.
- Prescaler:
  - Counts only in RUN/LAP and holds in PAUSE/IDLE.
  - At value TICK_DIV-1 while counting, the next edge sets it to 0 and increments time.
  - The first increment after IDLE->RUN occurs exactly TICK_DIV cycles after the state change.
- Time counter:
  - Digits roll over in cascade: cs_o 9 -> 0, cs_t 9 -> 0, sec_o 9 -> 0, sec_t 5 -> 0, min_o 9 -> 0, min_t 5 -> 0.
  - Pure BCD; no digit ever exceeds its max.
  - wrap is asserted for exactly the cycle after the 59:59.99 -> 00:00.00 increment.
- Display register:
  - disp_bcd is registered and one cycle behind the time counter in RUN/PAUSE/IDLE.
  - In LAP, disp_bcd holds the lap register, which captures the time value present on the cycle the lap pulse is accepted.
  - Counting continues underneath while in LAP.
- Boundary cases:
  - A tick coinciding with a start pulse in RUN: the increment happens, then the block pauses.
  - A tick coinciding with a lap pulse: the lap register captures the pre-increment value.
  - Pulses wider than one cycle are out of contract; each high cycle counts as a new press.

Decomposition:
- Package stopwatch_pkg:
  - state encoding (IDLE=0, RUN=1, LAP=2, PAUSE=3)
  - 4-bit BCD digit type
  - TIME_ZERO 24'h0 constant
  - digit max constants (9, 5)
- One natural sub-module, bcd_digit: parameter MAX, inputs clock, reset, clr, inc; outputs q[3:0], carry.
  - carry = inc && q==MAX.
  - Instantiated 6 times in a carry chain.
- FSM, prescaler and display mux stay in stopwatch_ctrl.

Test Plan:
1. Assert reset for 3 cycles -> disp_bcd=24'h000000, running=0, frozen=0, wrap=0; start held low for 1000 cycles -> no change.
2. TICK_DIV=4; start pulse, then 400 cycles -> disp_bcd=24'h000100 (00:01.00), running=1; first cs_o change exactly 4 cycles after running rises.
3. At 00:02.37 in RUN, lap pulse -> frozen=1 and disp_bcd holds 24'h000237 for 200 cycles; second lap pulse -> disp_bcd shows live 24'h000287+/-1 tick, frozen=0.
4. Start at 00:05.00 -> PAUSE, 100 cycles stable; clear and start asserted in the same cycle -> IDLE, disp_bcd=0 next cycle, running=0.
5. TICK_DIV=2; run 720000 cycles from zero -> wrap pulses once for one cycle, disp_bcd returns 24'h000000 then resumes at 00:00.01.
6. Reset at 00:03.45 mid-RUN while in LAP -> all outputs zero next cycle; following start resumes from 00:00.00.
